// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - data-memory request/response bundle between core and responder
//
// Purpose: groups the load/store request and the registered response of the
//          core's data-memory port.
// Signals:
//   req     core -> mem  access request, held until ready
//   we      core -> mem  1 = store, 0 = load
//   addr    core -> mem  byte address
//   wdata   core -> mem  store data, LSB-aligned
//   funct3  core -> mem  RV32I size/sign code
//   rdata   mem -> core  extended load result, valid with ready
//   ready   mem -> core  one-cycle response strobe
//   err     mem -> core  access rejected, valid with ready
// Modports: master (core side), slave (memory side).

interface data_mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   modport master (
      output req, we, addr, wdata, funct3,
      input  rdata, ready, err
   );

   modport slave (
      input  req, we, addr, wdata, funct3,
      output rdata, ready, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with wait states, lane handling and error checks
//
// Purpose: serves core load/store requests from an on-chip word RAM. A request is
//          accepted in IDLE, optionally delayed WAIT_CYCLES cycles, and answered
//          with a one-cycle ready strobe carrying rdata/err. The RAM access itself
//          happens at the edge that enters RESP.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous, active-high reset
//   bus     data_mem_responder_if.slave (req/we/addr/wdata/funct3 in,
//           rdata/ready/err out)
// Parameters:
//   DEPTH_WORDS  RAM size in 32-bit words (power of 2)
//   WAIT_CYCLES  extra latency cycles per access, 0..15
//   BASE_ADDR    byte address of word 0, 4-byte aligned

module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   data_mem_responder_if.slave        bus
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
   localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic        we_q;
   logic [31:0] wdata_q;
   logic [2:0]  f3_q;
   logic        ready_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   // The access is executed on the edge entering RESP. With no wait states that
   // edge is the accept edge itself, so the live request fields are used then;
   // otherwise the latched copies are.
   logic        from_idle;
   logic [31:0] acc_addr;
   logic        acc_we;
   logic [31:0] acc_wdata;
   logic [2:0]  acc_f3;
   logic        go_resp;

   assign from_idle = (state_q == S_IDLE);
   assign acc_addr  = from_idle ? bus.addr   : addr_q;
   assign acc_we    = from_idle ? bus.we     : we_q;
   assign acc_wdata = from_idle ? bus.wdata  : wdata_q;
   assign acc_f3    = from_idle ? bus.funct3 : f3_q;
   assign go_resp   = (from_idle && bus.req && NO_WAIT) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd0));

   // Error detection; range compare is done in 33 bits so the top bound cannot wrap.
   logic out_of_range;
   logic misaligned;
   logic bad_f3;
   logic acc_err;

   assign out_of_range = ({1'b0, acc_addr} < {1'b0, BASE_ADDR}) ||
                         ({1'b0, acc_addr} >= LIMIT);
   assign misaligned   = (((acc_f3 == 3'b001) || (acc_f3 == 3'b101)) && acc_addr[0]) ||
                         ((acc_f3 == 3'b010) && (acc_addr[1:0] != 2'b00));
   assign bad_f3       = acc_we ? (acc_f3[2] || (acc_f3[1:0] == 2'b11))
                                : ((acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111));
   assign acc_err      = out_of_range || misaligned || bad_f3;

   // Only the low address bits matter for indexing once the range check passed,
   // so the subtraction is done at index width.
   logic [AW+1:0] offset;
   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic [31:0]   rd_word;

   assign offset   = acc_addr[AW+1:0] - BASE_ADDR[AW+1:0];
   assign word_idx = offset[AW+1:2];
   assign lane     = acc_addr[1:0];
   assign rd_word  = mem_q[word_idx];

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_val;
   logic [31:0] wr_word;
   logic [31:0] resp_rdata;

   always_comb begin
      sel_byte = rd_word[{lane, 3'b000} +: 8];
      sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (acc_f3)
         3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
         3'b100:  load_val = {24'h0, sel_byte};
         3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
         3'b101:  load_val = {16'h0, sel_half};
         default: load_val = rd_word;
      endcase
   end

   // Read-modify-write merge keeps the unselected byte lanes.
   always_comb begin
      wr_word = rd_word;
      case (acc_f3[1:0])
         2'b00:   wr_word[{lane, 3'b000} +: 8]         = acc_wdata[7:0];
         2'b01:   wr_word[{lane[1], 4'b0000} +: 16]    = acc_wdata[15:0];
         default: wr_word                              = acc_wdata;
      endcase
   end

   assign resp_rdata = (acc_err || acc_we) ? 32'h0 : load_val;

   // RAM has no reset. Gating with rst_i keeps a zero-wait store from landing
   // while reset is held with req high.
   logic mem_we;
   assign mem_we = go_resp && acc_we && !acc_err && !rst_i;

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[word_idx] <= wr_word;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'h0;
         we_q    <= 1'b0;
         wdata_q <= 32'h0;
         f3_q    <= 3'b000;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         ready_q <= go_resp;
         err_q   <= go_resp && acc_err;
         if (go_resp) begin
            rdata_q <= resp_rdata;
         end
         case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  addr_q  <= bus.addr;
                  we_q    <= bus.we;
                  wdata_q <= bus.wdata;
                  f3_q    <= bus.funct3;
                  if (NO_WAIT) begin
                     state_q <= S_RESP;
                  end else begin
                     cnt_q   <= WAIT_LOAD;
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               // req still high here is ignored; it is re-sampled in IDLE.
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (1 and 3 wait states)

module tb_data_mem_responder;

   logic clk;
   logic rst1;
   logic rst3;
   int   cyc;

   data_mem_responder_if bus1 ();
   data_mem_responder_if bus3 ();

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut1 (
      .clk_i (clk),
      .rst_i (rst1),
      .bus   (bus1)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut3 (
      .clk_i (clk),
      .rst_i (rst3),
      .bus   (bus3)
   );

   typedef struct {
      logic [31:0] rd;
      logic        er;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   int   rt1[$];

   int n_checks;
   int n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Response monitors: every ready pulse must match the oldest expected entry.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (bus1.ready === 1'b1) begin
         rt1.push_back(cyc);
         if (q1.size() == 0) begin
            check("dut1_spurious_ready", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            check("dut1_rdata", bus1.rdata, e.rd);
            check("dut1_err", {31'h0, bus1.err}, {31'h0, e.er});
         end
      end
   end

   always @(negedge clk) begin : mon3
      exp_t e;
      if (bus3.ready === 1'b1) begin
         if (q3.size() == 0) begin
            check("dut3_spurious_ready", 32'd1, 32'd0);
         end else begin
            e = q3.pop_front();
            check("dut3_rdata", bus3.rdata, e.rd);
            check("dut3_err", {31'h0, bus3.err}, {31'h0, e.er});
         end
      end
   end

   // One access: push expectation, raise req at a negedge, wait for ready,
   // check latency in negedges (WAIT_CYCLES+1), then release req and idle a cycle.
   task automatic acc(input int sel, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [2:0] f3,
                      input logic [31:0] erd, input logic eer, input string tag);
      exp_t e;
      int   lat;
      logic rdy;
      e.rd = erd;
      e.er = eer;
      if (sel == 1) begin
         q1.push_back(e);
         bus1.req = 1'b1; bus1.we = we; bus1.addr = a; bus1.wdata = wd; bus1.funct3 = f3;
      end else begin
         q3.push_back(e);
         bus3.req = 1'b1; bus3.we = we; bus3.addr = a; bus3.wdata = wd; bus3.funct3 = f3;
      end
      lat = 0;
      rdy = 1'b0;
      while (!rdy && lat < 40) begin
         @(negedge clk);
         lat++;
         rdy = (sel == 1) ? bus1.ready : bus3.ready;
      end
      check({tag, "_latency"}, lat, (sel == 1) ? 32'd2 : 32'd4);
      if (sel == 1) bus1.req = 1'b0;
      else          bus3.req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int np;
      int guard;
      rst1 = 1'b1;
      rst3 = 1'b1;
      bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = 32'h0; bus1.wdata = 32'h0; bus1.funct3 = 3'b000;
      bus3.req = 1'b0; bus3.we = 1'b0; bus3.addr = 32'h0; bus3.wdata = 32'h0; bus3.funct3 = 3'b000;
      n_checks = 0;
      n_pass   = 0;

      repeat (2) @(negedge clk);
      check("rst_ready1", {31'h0, bus1.ready}, 32'd0);
      check("rst_err1",   {31'h0, bus1.err},   32'd0);
      check("rst_rdata1", bus1.rdata,          32'd0);
      check("rst_ready3", {31'h0, bus3.ready}, 32'd0);
      check("rst_err3",   {31'h0, bus3.err},   32'd0);
      check("rst_rdata3", bus3.rdata,          32'd0);
      rst1 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);

      // Word store/load round trip
      acc(1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, "sw10");
      acc(1, 1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, "lw10");

      // Byte store into an existing word, signed/unsigned byte loads
      acc(1, 1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0,        1'b0, "sw20");
      acc(1, 1'b1, 32'h21, 32'hFFFFFF80, 3'b000, 32'h0,        1'b0, "sb21");
      acc(1, 1'b0, 32'h20, 32'h0,        3'b010, 32'h11228044, 1'b0, "lw20");
      acc(1, 1'b0, 32'h21, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, "lb21");
      acc(1, 1'b0, 32'h21, 32'h0,        3'b100, 32'h00000080, 1'b0, "lbu21");

      // Halfword store in the upper half, loads, misaligned halfword
      acc(1, 1'b1, 32'h30, 32'h0,        3'b010, 32'h0,        1'b0, "sw30");
      acc(1, 1'b1, 32'h32, 32'h1234BEEF, 3'b001, 32'h0,        1'b0, "sh32");
      acc(1, 1'b0, 32'h32, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0, "lh32");
      acc(1, 1'b0, 32'h32, 32'h0,        3'b101, 32'h0000BEEF, 1'b0, "lhu32");
      acc(1, 1'b0, 32'h30, 32'h0,        3'b010, 32'hBEEF0000, 1'b0, "lw30");
      acc(1, 1'b0, 32'h33, 32'h0,        3'b001, 32'h0,        1'b1, "lh33");

      // Rejected accesses must not touch RAM
      acc(1, 1'b1, 32'h3FC, 32'h12345678, 3'b010, 32'h0,        1'b0, "sw3fc");
      acc(1, 1'b1, 32'h3FE, 32'hAAAAAAAA, 3'b010, 32'h0,        1'b1, "sw3fe_mis");
      acc(1, 1'b1, 32'h403, 32'hAAAAAAAA, 3'b010, 32'h0,        1'b1, "sw403");
      acc(1, 1'b1, 32'h400, 32'hAAAAAAAA, 3'b010, 32'h0,        1'b1, "sw400_oor");
      acc(1, 1'b1, 32'h3FC, 32'hAAAAAAAA, 3'b100, 32'h0,        1'b1, "sbu_illegal");
      acc(1, 1'b0, 32'h3FC, 32'h0,        3'b011, 32'h0,        1'b1, "ld011_illegal");
      acc(1, 1'b0, 32'h3FC, 32'h0,        3'b010, 32'h12345678, 1'b0, "lw3fc");
      acc(1, 1'b0, 32'hFFFFFFFC, 32'h0,   3'b010, 32'h0,        1'b1, "lw_top");

      // Back-to-back loads with req held through RESP
      rt1.delete();
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.rd = 32'hDEADBEEF;
         e.er = 1'b0;
         q1.push_back(e);
      end
      bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h10; bus1.funct3 = 3'b010;
      np = 0;
      guard = 0;
      while (np < 3 && guard < 40) begin
         @(negedge clk);
         guard++;
         if (bus1.ready) np++;
      end
      bus1.req = 1'b0;
      check("b2b_pulses_seen", np, 32'd3);
      repeat (8) @(negedge clk);
      check("b2b_pulse_count", rt1.size(), 32'd3);
      if (rt1.size() == 3) begin
         check("b2b_spacing_0", rt1[1] - rt1[0], 32'd3);
         check("b2b_spacing_1", rt1[2] - rt1[1], 32'd3);
      end

      // Reset during a 3-wait-state store abandons it
      acc(3, 1'b1, 32'h40, 32'h0,        3'b010, 32'h0,        1'b0, "w3_sw40_zero");
      acc(3, 1'b0, 32'h40, 32'h0,        3'b010, 32'h0,        1'b0, "w3_lw40_a");
      bus3.req = 1'b1; bus3.we = 1'b1; bus3.addr = 32'h40; bus3.wdata = 32'hCAFEF00D; bus3.funct3 = 3'b010;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("w3_ready_before_rst", {31'h0, bus3.ready}, 32'd0);
      rst3 = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("w3_ready_in_rst", {31'h0, bus3.ready}, 32'd0);
      end
      bus3.req = 1'b0;
      rst3 = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("w3_ready_after_rst", {31'h0, bus3.ready}, 32'd0);
      end
      acc(3, 1'b0, 32'h40, 32'h0,        3'b010, 32'h0,        1'b0, "w3_lw40_b");
      acc(3, 1'b1, 32'h44, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0, "w3_sw44");
      acc(3, 1'b0, 32'h44, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, "w3_lw44");

      repeat (4) @(negedge clk);
      check("q1_drained", q1.size(), 32'd0);
      check("q3_drained", q3.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
